multicycle_control: RTL and testbench

Main control FSM for the multi-cycle LEGv8 datapath. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and decodes the 11-bit opcode into datapath strobes. It generates the 2-bit alu_op consumed by the execute-stage ALU control decoder (00 = D-type add, 01 = branch pass-B, 10 = R-type). It handshakes with unified memory via mem_ready and counts retired instructions.

---
 rtl/multicycle_control.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multi-cycle LEGv8 datapath. Sequences
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, decodes the 11-bit opcode into
//   datapath strobes, handshakes with unified memory through mem_ready (with a
//   bounded wait that ends in a sticky bus error) and counts retired
//   instructions.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   opcode      in   instruction[31:21] from IR, valid from DECODE onward
//   zero        in   ALU zero flag, valid during EXECUTE
//   mem_ready   in   memory access completes this cycle
//   pc_write    out  load PC this cycle
//   pc_src      out  0 = PC+4, 1 = branch target
//   ir_write    out  load IR from memory read data
//   instr_fetch out  memory address mux selects PC
//   mem_read    out  memory read request
//   mem_write   out  memory write request
//   alu_op      out  00 = add, 01 = pass-B (branch), 10 = R-type
//   alu_src     out  ALU B = sign-extended immediate
//   reg2_loc    out  read-register-2 = Rt (instr[4:0])
//   reg_write   out  register file write enable
//   mem_to_reg  out  writeback selects memory data
//   state       out  current state encoding
//   halted      out  sticky: illegal opcode or bus error
//   bus_error   out  sticky: memory wait timeout
//   retired     out  instructions completed (wraps)
//
// The strobes respond to mem_ready and zero in the same cycle (memory
// completion and the CBZ decision are Mealy), so they are decoded from the
// registered state/class and forced low while reset is high. state, halted,
// bus_error and retired come straight from registers.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int WAIT_LIMIT = 16,
  parameter int RETIRE_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                instr_fetch,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                reg2_loc,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [2:0]          state,
  output logic                halted,
  output logic                bus_error,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE   = 3'd0,
    C_LDUR    = 3'd1,
    C_STUR    = 3'd2,
    C_CBZ     = 3'd3,
    C_B       = 3'd4,
    C_ILLEGAL = 3'd5
  } class_t;

  // Opcode class decode; anything not explicitly recognised is illegal.
  function automatic class_t decode_class(input logic [10:0] op);
    class_t c;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: c = C_RTYPE;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      default:         c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t              r_state;
  class_t              r_class;
  logic [7:0]          r_wait_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_halted;
  logic                r_bus_error;

  class_t              w_dec_class;
  logic                w_wait_limit;
  logic                w_timeout;

  assign w_dec_class  = decode_class(opcode);
  // Counter has already spent WAIT_LIMIT cycles waiting; mem_ready this cycle
  // still completes the access, otherwise the access is abandoned.
  assign w_wait_limit = (r_wait_cnt == 8'(WAIT_LIMIT));
  assign w_timeout    = w_wait_limit && !mem_ready;

  // State sequencing, class latch, wait counter, retire counter, sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_class     <= C_RTYPE;
      r_wait_cnt  <= 8'd0;
      r_retired   <= '0;
      r_halted    <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_wait_cnt <= 8'd0;
            r_state    <= S_DECODE;
          end else if (w_wait_limit) begin
            r_bus_error <= 1'b1;
            r_halted    <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          r_class <= w_dec_class;
          case (w_dec_class)
            C_ILLEGAL: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            C_B: begin
              r_retired <= r_retired + RETIRE_W'(1);
              r_state   <= S_FETCH;
            end
            default: r_state <= S_EXECUTE;
          endcase
        end
        S_EXECUTE: begin
          case (r_class)
            C_RTYPE:        r_state <= S_WRITEBACK;
            C_LDUR, C_STUR: r_state <= S_MEMORY;
            C_CBZ: begin
              r_retired <= r_retired + RETIRE_W'(1);
              r_state   <= S_FETCH;
            end
            default: begin
              // Only legal classes reach EXECUTE; treat corruption as fatal.
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
          endcase
        end
        S_MEMORY: begin
          if (mem_ready) begin
            r_wait_cnt <= 8'd0;
            if (r_class == C_LDUR) begin
              r_state <= S_WRITEBACK;
            end else begin
              r_retired <= r_retired + RETIRE_W'(1);
              r_state   <= S_FETCH;
            end
          end else if (w_wait_limit) begin
            r_bus_error <= 1'b1;
            r_halted    <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WRITEBACK: begin
          r_retired <= r_retired + RETIRE_W'(1);
          r_state   <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase
    end
  end

  // Datapath strobe decode; everything idles low while reset is asserted.
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ir_write    = 1'b0;
    instr_fetch = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_op      = 2'b00;
    alu_src     = 1'b0;
    reg2_loc    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    if (reset) begin
      pc_write = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!w_timeout) begin
            instr_fetch = 1'b1;
            mem_read    = 1'b1;
            ir_write    = mem_ready;
            pc_write    = mem_ready;
          end else begin
            instr_fetch = 1'b0;
          end
        end
        S_DECODE: begin
          reg2_loc = (w_dec_class == C_STUR) || (w_dec_class == C_CBZ);
          if (w_dec_class == C_B) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end else begin
            pc_write = 1'b0;
          end
        end
        S_EXECUTE: begin
          case (r_class)
            C_RTYPE: alu_op = 2'b10;
            C_LDUR:  alu_src = 1'b1;
            C_STUR: begin
              alu_src  = 1'b1;
              reg2_loc = 1'b1;
            end
            C_CBZ: begin
              alu_op   = 2'b01;
              reg2_loc = 1'b1;
              pc_write = zero;
              pc_src   = 1'b1;
            end
            default: alu_op = 2'b00;
          endcase
        end
        S_MEMORY: begin
          // alu_op stays 00 with alu_src=1 so the address is held stable.
          if (!w_timeout) begin
            alu_src = 1'b1;
            if (r_class == C_LDUR) begin
              mem_read = 1'b1;
            end else begin
              mem_write = 1'b1;
              reg2_loc  = 1'b1;
            end
          end else begin
            alu_src = 1'b0;
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_class == C_LDUR);
        end
        default: reg_write = 1'b0;
      endcase
    end
  end

  assign state     = r_state;
  assign halted    = r_halted;
  assign bus_error = r_bus_error;
  assign retired   = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed plus randomized bench for multicycle_control. The reference model
//   walks each instruction through its phase list (fetch wait, decode, execute,
//   memory wait, writeback) derived from the opcode class and the chosen
//   mem_ready delays, and predicts state, strobes, retired and the sticky
//   flags for every cycle. Inputs change on the falling edge; outputs are
//   sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int WL = 16;
  localparam int RW = 32;

  // Strobe vector bit masks: {pc_write,pc_src,ir_write,instr_fetch,mem_read,
  // mem_write,alu_op[1:0],alu_src,reg2_loc,reg_write,mem_to_reg}
  localparam logic [11:0] M_PCW  = 12'h800;
  localparam logic [11:0] M_PCS  = 12'h400;
  localparam logic [11:0] M_IRW  = 12'h200;
  localparam logic [11:0] M_IF   = 12'h100;
  localparam logic [11:0] M_MR   = 12'h080;
  localparam logic [11:0] M_MW   = 12'h040;
  localparam logic [11:0] M_AOPR = 12'h020;
  localparam logic [11:0] M_AOPB = 12'h010;
  localparam logic [11:0] M_ASRC = 12'h008;
  localparam logic [11:0] M_R2L  = 12'h004;
  localparam logic [11:0] M_RW   = 12'h002;
  localparam logic [11:0] M_M2R  = 12'h001;
  localparam logic [11:0] M_NONE = 12'h000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   opcode;
  logic          zero;
  logic          mem_ready;
  logic          pc_write, pc_src, ir_write, instr_fetch, mem_read, mem_write;
  logic [1:0]    alu_op;
  logic          alu_src, reg2_loc, reg_write, mem_to_reg;
  logic [2:0]    state;
  logic          halted, bus_error;
  logic [RW-1:0] retired;
  logic [11:0]   strb;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] m_retired;
  logic          m_halted;
  logic          m_bus;

  multicycle_control #(.WAIT_LIMIT(WL), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .instr_fetch(instr_fetch), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .alu_src(alu_src),
    .reg2_loc(reg2_loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .state(state), .halted(halted), .bus_error(bus_error), .retired(retired)
  );

  assign strb = {pc_write, pc_src, ir_write, instr_fetch, mem_read, mem_write,
                 alu_op, alu_src, reg2_loc, reg_write, mem_to_reg};

  always #5 clk = ~clk;

  function automatic kind_t classify(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
    if (op == OP_LDUR) return K_LD;
    if (op == OP_STUR) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, check everything, advance to next negedge.
  task automatic cyc(input logic mr, input logic [2:0] es, input logic [11:0] ex);
    mem_ready = mr;
    #1;
    chk("state", 64'(state), 64'(es));
    chk("strobes", 64'(strb), 64'(ex));
    chk("retired", 64'(retired), 64'(m_retired));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("bus_error", 64'(bus_error), 64'(m_bus));
    @(negedge clk);
  endtask

  // A memory handshake phase that completes after 'delay' idle cycles or
  // times out once WL idle cycles have elapsed.
  task automatic wait_phase(input logic [2:0] st, input int delay,
                            input logic [11:0] busy, input logic [11:0] fin,
                            output logic ok);
    ok = 1'b0;
    for (int k = 0; k <= WL; k++) begin
      if (k == delay) begin
        cyc(1'b1, st, fin);
        ok = 1'b1;
        return;
      end
      if (k == WL) begin
        cyc(1'b0, st, M_NONE);
        m_halted = 1'b1;
        m_bus    = 1'b1;
        return;
      end
      cyc(1'b0, st, busy);
    end
  endtask

  task automatic run_instr(input logic [10:0] op, input logic z, input int fd, input int md);
    kind_t       k;
    logic        ok;
    logic [11:0] ex;
    logic [11:0] mem_strb;
    k      = classify(op);
    opcode = op;
    zero   = z;
    wait_phase(3'd0, fd, M_IF | M_MR, M_IF | M_MR | M_IRW | M_PCW, ok);
    if (!ok) return;
    ex = M_NONE;
    if (k == K_ST || k == K_CBZ) ex = ex | M_R2L;
    if (k == K_B) ex = ex | M_PCW | M_PCS;
    cyc(rnd1(), 3'd1, ex);
    if (k == K_ILL) begin
      m_halted = 1'b1;
      return;
    end
    if (k == K_B) begin
      m_retired++;
      return;
    end
    case (k)
      K_R:     ex = M_AOPR;
      K_LD:    ex = M_ASRC;
      K_ST:    ex = M_ASRC | M_R2L;
      default: ex = M_AOPB | M_R2L | M_PCS | (z ? M_PCW : M_NONE);
    endcase
    cyc(rnd1(), 3'd2, ex);
    if (k == K_CBZ) begin
      m_retired++;
      return;
    end
    if (k == K_LD || k == K_ST) begin
      mem_strb = (k == K_LD) ? (M_MR | M_ASRC) : (M_MW | M_ASRC | M_R2L);
      wait_phase(3'd3, md, mem_strb, mem_strb, ok);
      if (!ok) return;
      if (k == K_ST) begin
        m_retired++;
        return;
      end
    end
    cyc(rnd1(), 3'd4, (k == K_LD) ? (M_RW | M_M2R) : M_RW);
    m_retired++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(rnd1(), 3'd7, M_NONE);
  endtask

  // Raise reset at a falling edge, check its immediate effect, release it.
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_strobes", 64'(strb), 64'd0);
    mem_ready = 1'b1;
    #1;
    chk("rst_strobes_ready", 64'(strb), 64'd0);
    m_retired = '0;
    m_halted  = 1'b0;
    m_bus     = 1'b0;
    chk("rst_retired", 64'(retired), 64'(m_retired));
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_bus_error", 64'(bus_error), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [10:0] op;
    int          sel;
    int          fd;
    int          md;
    reset     = 1'b1;
    opcode    = 11'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    m_retired = '0;
    m_halted  = 1'b0;
    m_bus     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // ADD with memory always ready: 0,1,2,4 then back to FETCH.
    run_instr(OP_ADD, 1'b0, 0, 0);
    // LDUR with a 3-cycle fetch delay: 4 FETCH cycles then 1,2,3,4.
    run_instr(OP_LDUR, 1'b0, 3, 0);
    // CBZ taken then not taken.
    run_instr({8'b10110100, 3'b101}, 1'b1, 0, 0);
    run_instr({8'b10110100, 3'b010}, 1'b0, 0, 0);

    // Reset in the middle of an LDUR memory wait.
    opcode = OP_LDUR;
    zero   = 1'b0;
    cyc(1'b1, 3'd0, M_IF | M_MR | M_IRW | M_PCW);
    cyc(1'b0, 3'd1, M_NONE);
    cyc(1'b0, 3'd2, M_ASRC);
    cyc(1'b0, 3'd3, M_MR | M_ASRC);
    cyc(1'b0, 3'd3, M_MR | M_ASRC);
    do_reset();

    // Randomized legal instruction stream.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       op = OP_ADD;
        1:       op = OP_SUB;
        2:       op = OP_AND;
        3:       op = OP_ORR;
        4:       op = OP_LDUR;
        5:       op = OP_STUR;
        6:       op = {8'b10110100, 3'($urandom_range(0, 7))};
        default: op = {6'b000101, 5'($urandom_range(0, 31))};
      endcase
      fd = ($urandom_range(0, 7) == 0) ? WL : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 5) == 0) ? WL : int'($urandom_range(0, 3));
      run_instr(op, rnd1(), fd, md);
    end

    // Illegal opcode: DECODE then HALT, sticky until reset.
    run_instr(OP_ILL, 1'b0, 0, 0);
    halt_cycles(20);
    do_reset();

    // STUR memory timeout: 16 idle wait cycles, then a strobe-free cycle.
    run_instr(OP_STUR, 1'b0, 0, WL + 1);
    halt_cycles(5);
    do_reset();

    // Fetch timeout.
    run_instr(OP_ADD, 1'b0, WL + 1, 0);
    halt_cycles(3);
    do_reset();

    // mem_ready arriving exactly at the wait limit completes normally.
    run_instr(OP_STUR, 1'b0, 0, WL);
    cyc(1'b0, 3'd0, M_IF | M_MR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
